arb_requester: RTL
==================

Name: arb_requester

Overview:
- Client-side endpoint of the two-wire request/grant arbitration handshake (request R out, grant A in).
- Local logic pulses start with a hold length. The block raises R and waits for A, then asserts owner for exactly len cycles. It then releases R and waits for A to drop before accepting new work.
- Adds a grant timeout and grant-revocation detection. One instance sits in front of each arbiter port.

Parameters:
- CNT_W, 8: width of len and internal counters.
- TIMEOUT, 255: maximum cycles R stays high without a grant. Must be ≥1 and < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request pulse from local logic.
- len  in  CNT_W  ownership length in cycles; sampled with start.
- A  in  1  grant from arbiter; treated as asynchronous.
- R  out  1  request to arbiter; registered.
- owner  out  1  high while the shared resource may be used.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at normal release.
- timeout  out  1  one-cycle pulse when the grant wait expires.
- revoked  out  1  one-cycle pulse when A drops during ownership.

Behaviour:
- Reset (async, any state): state=IDLE; R, owner, busy, done, timeout, revoked=0; sync flops=0; counters=0. R falls immediately when rst asserts, including mid-transaction.
- A passes through a 2-flop synchronizer; a_s is the second flop. Grant and release observation each cost 2 cycles of latency.
- All outputs are registered. done, timeout and revoked are never high together.
- IDLE:
  - start=1 and len≠0: latch len, clear wait_cnt, R=1, busy=1, go to REQ.
  - start with len=0: ignored, no output change.
- REQ:
  - If a_s=1: go to OWN, owner=1, hold_cnt=len.
  - Else if wait_cnt==TIMEOUT-1: R=0, timeout=1 for one cycle, go to REL.
  - Else wait_cnt+1.
  - Net effect: with no grant, R is high exactly TIMEOUT cycles.
- OWN:
  - owner stays high for exactly len cycles; hold_cnt decrements each cycle.
  - On the last cycle: R=0, owner=0, done=1 for one cycle, go to REL.
  - If a_s=0 at any OWN cycle (revocation): R=0, owner=0, revoked=1 for one cycle, go to REL. This takes priority over normal completion in the same cycle.
- REL:
  - R=0, busy=1. Wait for a_s==0, then go to IDLE with busy=0.
  - Covers late grants arriving after a timeout.
  - A start arriving in the same cycle as the REL→IDLE transition is ignored.
- start while busy=1: ignored, not queued.
- Cycle timing with a combinational arbiter (start sampled at edge 0):
  - R=1 after edge 0.
  - owner=1 after edge 3.
  - owner=0 and done=1 after edge 3+len.
  - busy=0 after edge 3+len+3.
- Counters saturate-free: len ≤ 2^CNT_W−1, TIMEOUT < 2^CNT_W. No wrap-around is possible.

Test Plan:
- Single grant: A follows R immediately; start with len=4 at edge 0 → R high edges 0..7, owner high exactly 4 cycles after edge 3, done pulse after edge 7, busy low after edge 10.
- Timeout: TIMEOUT=8, A tied 0; start with len=3 → R high exactly 8 cycles, one timeout pulse, owner never high, busy low 1 cycle later.
- Revocation: grant, then A forced 0 two cycles into len=10 ownership → owner falls 2 cycles after A drops, revoked pulse, no done, R=0, return to IDLE.
- Contention: two instances on a 2-way arbiter both start same cycle with len=5 → owners never overlap; loser gets owner within 5+4 cycles of winner's done; each emits exactly one done.
- Ignored starts: start with len=0 in IDLE → no R. start pulses during REQ/OWN/REL → no second transaction, exactly one done.
- Reset mid-OWN: rst asserted during ownership → R, owner, busy go 0 immediately. After release, a new start with len=2 completes normally.

Source files
------------

// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
// Module   : arb_requester
// Purpose  : Client-side endpoint of a two-wire request/grant arbitration
//            handshake. A start pulse (with a hold length) raises R, waits for
//            the synchronised grant, holds ownership for len cycles, then drops
//            R and waits for the grant to fall before accepting new work.
//            Adds a grant-wait timeout and detection of grant revocation.
// Ports    : clk     - system clock, rising edge
//            rst     - asynchronous active-high reset
//            start   - one-cycle request pulse from local logic
//            len     - ownership length in cycles, sampled with start
//            A       - grant from arbiter (asynchronous, synchronised here)
//            R       - request to arbiter (registered)
//            owner   - high while the shared resource may be used
//            busy    - high in any state other than IDLE
//            done    - one-cycle pulse at normal release
//            timeout - one-cycle pulse when the grant wait expires
//            revoked - one-cycle pulse when the grant drops during ownership
// Revision : 1.0 - initial release
// ============================================================================
module arb_requester #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             A,
    output logic             R,
    output logic             owner,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             revoked
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OWN  = 2'd2,
        S_REL  = 2'd3
    } state_t;

    // Last wait count before giving up: R is then high exactly TIMEOUT cycles.
    localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    state_t           state_q,    state_d;
    logic             a_meta_q,   a_meta_d;
    logic             a_s_q,      a_s_d;
    logic [CNT_W-1:0] len_q,      len_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             r_q,        r_d;
    logic             owner_q,    owner_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             timeout_q,  timeout_d;
    logic             revoked_q,  revoked_d;

    always_comb begin
        state_d    = state_q;
        a_meta_d   = A;
        a_s_d      = a_meta_q;
        len_d      = len_q;
        wait_cnt_d = wait_cnt_q;
        hold_cnt_d = hold_cnt_q;
        r_d        = r_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        revoked_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A zero-length request is meaningless and is dropped.
                if (start && (len != '0)) begin
                    len_d      = len;
                    wait_cnt_d = '0;
                    r_d        = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (a_s_q) begin
                    owner_d    = 1'b1;
                    hold_cnt_d = len_q;
                    state_d    = S_OWN;
                end else if (wait_cnt_q == c_WAIT_LAST) begin
                    r_d       = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_REL;
                end else begin
                    wait_cnt_d = wait_cnt_q + c_ONE;
                end
            end
            S_OWN: begin
                // Revocation wins over a completion landing in the same cycle.
                if (!a_s_q) begin
                    r_d       = 1'b0;
                    owner_d   = 1'b0;
                    revoked_d = 1'b1;
                    state_d   = S_REL;
                end else if (hold_cnt_q == c_ONE) begin
                    r_d     = 1'b0;
                    owner_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_REL;
                end else begin
                    hold_cnt_d = hold_cnt_q - c_ONE;
                end
            end
            S_REL: begin
                // Also absorbs a grant that shows up after a timeout.
                if (!a_s_q) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_meta_q   <= 1'b0;
            a_s_q      <= 1'b0;
            len_q      <= '0;
            wait_cnt_q <= '0;
            hold_cnt_q <= '0;
            r_q        <= 1'b0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            revoked_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_meta_q   <= a_meta_d;
            a_s_q      <= a_s_d;
            len_q      <= len_d;
            wait_cnt_q <= wait_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            r_q        <= r_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            revoked_q  <= revoked_d;
        end
    end

    assign R       = r_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign revoked = revoked_q;

endmodule
`default_nettype wire
